// File: rtl/cpu_types_pkg.sv
// Shared types for the pipelined MIPS datapath: register selects, scoreboard
// entries and the hazard cause chosen each cycle by hazard_fwd_ctrl.
package cpu_types_pkg;

    localparam int REG_AW_DEF = 5;

    typedef logic [REG_AW_DEF-1:0] regbits_t;

    typedef struct packed {
        logic     valid;
        logic     wen;
        regbits_t wsel;
        logic     is_load;
    } sb_entry_t;

    // Ordered from highest to lowest priority.
    typedef enum logic [2:0] {
        HZ_NONE     = 3'd0,
        HZ_HALT     = 3'd1,
        HZ_DMISS    = 3'd2,
        HZ_REDIRECT = 3'd3,
        HZ_LOADUSE  = 3'd4,
        HZ_IMISS    = 3'd5
    } hazard_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight register writers (entry 0 = EX ... last = WB)
// and the per-entry writer-match vectors for the ID and EX source registers.
module hazard_scoreboard #(
    parameter int PIPE_DEPTH = 3,
    parameter int REG_AW     = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_advance,
    input  logic                  i_push,
    input  logic                  i_wen,
    input  logic [REG_AW-1:0]     i_wsel,
    input  logic                  i_is_load,
    input  logic [REG_AW-1:0]     i_id_rs,
    input  logic [REG_AW-1:0]     i_id_rt,
    input  logic [REG_AW-1:0]     i_ex_rs,
    input  logic [REG_AW-1:0]     i_ex_rt,
    output logic [PIPE_DEPTH-1:0] o_match_id_rs,
    output logic [PIPE_DEPTH-1:0] o_match_id_rt,
    output logic [PIPE_DEPTH-1:0] o_match_ex_rs,
    output logic [PIPE_DEPTH-1:0] o_match_ex_rt,
    output logic                  o_head_load
);

    typedef struct packed {
        logic              valid;
        logic              wen;
        logic [REG_AW-1:0] wsel;
        logic              is_load;
    } slot_t;

    slot_t r_sb [PIPE_DEPTH];

    // $zero is hard-wired, so a writer targeting it never creates a dependency.
    function automatic logic f_match(input slot_t e, input logic [REG_AW-1:0] r);
        return e.valid & e.wen & (e.wsel == r) & (r != '0);
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                r_sb[k].valid <= 1'b0;
            end
        end else if (i_advance) begin
            r_sb[0] <= i_push ? {1'b1, i_wen, i_wsel, i_is_load} : '0;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                r_sb[k] <= r_sb[k-1];
            end
        end
    end

    always_comb begin
        o_match_id_rs = '0;
        o_match_id_rt = '0;
        o_match_ex_rs = '0;
        o_match_ex_rt = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            o_match_id_rs[k] = f_match(r_sb[k], i_id_rs);
            o_match_id_rt[k] = f_match(r_sb[k], i_id_rt);
            o_match_ex_rs[k] = f_match(r_sb[k], i_ex_rs);
            o_match_ex_rt[k] = f_match(r_sb[k], i_ex_rt);
        end
    end

    assign o_head_load = r_sb[0].is_load;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller: stage enables/flushes, EX forwarding selects,
// sticky halt and stall counter. Forwarding is built only with FORWARDING_EN.
module hazard_fwd_ctrl
    import cpu_types_pkg::*;
#(
    parameter  int PIPE_DEPTH = 3,
    parameter  int REG_AW     = REG_AW_DEF,
    parameter  int CNT_W      = 32,
    localparam int FSW        = $clog2(PIPE_DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dmem_req,
    input  logic              dhit,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wen,
    input  logic [REG_AW-1:0] id_wsel,
    input  logic              id_is_load,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_redirect,
    input  logic              wb_halt,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exm_en,
    output logic              mwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [FSW-1:0]    fwd_a,
    output logic [FSW-1:0]    fwd_b,
    output logic              halt,
    output logic [CNT_W-1:0]  stall_cycles
);

    logic                  r_halt;
    logic [CNT_W-1:0]      r_stall;
    logic [PIPE_DEPTH-1:0] w_m_id_rs;
    logic [PIPE_DEPTH-1:0] w_m_id_rt;
    logic [PIPE_DEPTH-1:0] w_m_ex_rs;
    logic [PIPE_DEPTH-1:0] w_m_ex_rt;
    logic                  w_head_load;
    logic                  w_dmiss;
    logic                  w_load_use;
    logic                  w_push;
    hazard_e               w_cause;

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    hazard_scoreboard #(
        .PIPE_DEPTH (PIPE_DEPTH),
        .REG_AW     (REG_AW)
    ) u_sb (
        .CLK           (CLK),
        .RST           (RST),
        .i_advance     (mwb_en),
        .i_push        (w_push),
        .i_wen         (id_wen),
        .i_wsel        (id_wsel),
        .i_is_load     (id_is_load),
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .i_ex_rs       (ex_rs),
        .i_ex_rt       (ex_rt),
        .o_match_id_rs (w_m_id_rs),
        .o_match_id_rt (w_m_id_rt),
        .o_match_ex_rs (w_m_ex_rs),
        .o_match_ex_rt (w_m_ex_rt),
        .o_head_load   (w_head_load)
    );

    assign w_dmiss = dmem_req & ~dhit;
    assign w_push  = idex_en & ~idex_flush;

`ifdef FORWARDING_EN
    // Only a load in EX is too late to forward; everything older reaches EX in time.
    assign w_load_use = w_head_load &
                        ((id_use_rs & w_m_id_rs[0]) | (id_use_rt & w_m_id_rt[0]));

    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
            if (w_m_ex_rs[k]) fwd_a = FSW'(k);
            if (w_m_ex_rt[k]) fwd_b = FSW'(k);
        end
    end

    logic w_unused_fwd;
    assign w_unused_fwd = ^{w_m_id_rs[PIPE_DEPTH-1:1], w_m_id_rt[PIPE_DEPTH-1:1],
                            w_m_ex_rs[0], w_m_ex_rt[0]};
`else
    // Without forwarding any in-flight writer blocks the reader until it retires.
    assign w_load_use = (id_use_rs & (|w_m_id_rs)) | (id_use_rt & (|w_m_id_rt));
    assign fwd_a      = '0;
    assign fwd_b      = '0;

    logic w_unused_fwd;
    assign w_unused_fwd = ^{w_m_ex_rs, w_m_ex_rt, w_head_load};
`endif

    always_comb begin
        w_cause = HZ_NONE;
        if (r_halt)           w_cause = HZ_HALT;
        else if (w_dmiss)     w_cause = HZ_DMISS;
        else if (ex_redirect) w_cause = HZ_REDIRECT;
        else if (w_load_use)  w_cause = HZ_LOADUSE;
        else if (!ihit)       w_cause = HZ_IMISS;
    end

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exm_en     = 1'b0;
        mwb_en     = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!RST) begin
            case (w_cause)
                HZ_NONE: begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                    idex_en = 1'b1;
                    exm_en  = 1'b1;
                    mwb_en  = 1'b1;
                end
                HZ_REDIRECT: begin
                    pc_en      = ihit;
                    ifid_en    = 1'b1;
                    idex_en    = 1'b1;
                    exm_en     = 1'b1;
                    mwb_en     = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
                HZ_LOADUSE, HZ_IMISS: begin
                    idex_en    = 1'b1;
                    exm_en     = 1'b1;
                    mwb_en     = 1'b1;
                    idex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_halt  <= 1'b0;
            r_stall <= '0;
        end else begin
            r_halt <= r_halt | wb_halt;
            if (!pc_en && !r_halt) r_stall <= f_sat_inc(r_stall);
        end
    end

    assign halt         = r_halt;
    assign stall_cycles = r_stall;

endmodule
